alu_srcb_stage: RTL and testbench

Parametrised, registered successor to the ALU operand-B selector in the multicycle datapath. It selects and forms operand B from register B, a constant, or an immediate in one of several extension/shift modes. The result passes through a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU stage can stall without losing an operand. It sits between the register-read/sign-extend logic and the ALU's B input.

---
 rtl/alu_srcb_pkg.sv | 25 ++
 rtl/skid_buffer2.sv | 84 ++++++++
 rtl/alu_srcb_stage.sv | 87 ++++++++
 tb/tb_alu_srcb_stage.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_srcb_pkg.sv
// Shared definitions for the ALU operand-B stage: sel encodings and
// occupancy states of the two-entry output buffer.
package alu_srcb_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_REGB     = 3'd0;
  localparam logic [SEL_W-1:0] SEL_CONST    = 3'd1;
  localparam logic [SEL_W-1:0] SEL_SEXT     = 3'd2;
  localparam logic [SEL_W-1:0] SEL_SEXT_SHL = 3'd3;
  localparam logic [SEL_W-1:0] SEL_ZEXT     = 3'd4;
  localparam logic [SEL_W-1:0] SEL_LUI      = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  // Encodings 6 and 7 are reserved and form a zero operand.
  function automatic logic sel_is_reserved(input logic [SEL_W-1:0] s);
    return (s > SEL_LUI);
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry FIFO skid buffer with registered in_ready/out_valid and a flush
// that empties it. Head entry drives out_data and holds it while stalled.
module skid_buffer2
  import alu_srcb_pkg::*;
#(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  occ_t          state_q;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          push;
  logic          pop;

  // A flush cycle neither stores the presented request nor counts a pop.
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid_q && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_q      <= in_data;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q     <= in_data;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can change state.
          if (pop) begin
            head_q     <= tail_q;
            state_q    <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

endmodule

// File: rtl/alu_srcb_stage.sv
// ALU operand-B former: selects register B, a constant or an extended/shifted
// immediate and hands it to the ALU through a two-entry skid buffer.
module alu_srcb_stage
  import alu_srcb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_W     = 16,
  parameter int CONST_VAL = 4,
  parameter int SHAMT     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [IMM_W-1:0] imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             illegal_sel
);

  localparam int LUI_W = WIDTH + IMM_W + 16;
  localparam int BUF_W = WIDTH + SEL_W;

  logic [WIDTH-1:0] sext_imm;
  logic [WIDTH-1:0] sext_shl_imm;
  logic [WIDTH-1:0] zext_imm;
  logic [LUI_W-1:0] lui_wide;
  logic [WIDTH-1:0] operand_d;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;
  logic             accept;
  logic             illegal_q;

  assign sext_imm     = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign sext_shl_imm = sext_imm << SHAMT;
  assign zext_imm     = {{(WIDTH-IMM_W){1'b0}}, imm};
  // Built wide then truncated so narrower WIDTH values simply drop upper imm bits.
  assign lui_wide     = {{WIDTH{1'b0}}, imm, 16'h0000};

  always_comb begin
    operand_d = '0;
    case (sel)
      SEL_REGB:     operand_d = reg_b;
      SEL_CONST:    operand_d = WIDTH'(CONST_VAL);
      SEL_SEXT:     operand_d = sext_imm;
      SEL_SEXT_SHL: operand_d = sext_shl_imm;
      SEL_ZEXT:     operand_d = zext_imm;
      SEL_LUI:      operand_d = lui_wide[WIDTH-1:0];
      default:      operand_d = '0;
    endcase
  end

  assign accept = in_valid && in_ready && !flush;
  assign buf_in = {sel, operand_d};

  skid_buffer2 #(
    .DW(BUF_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (buf_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_q <= 1'b0;
    end else if (accept && sel_is_reserved(sel)) begin
      illegal_q <= 1'b1;
    end
  end

  assign out_data    = buf_out[WIDTH-1:0];
  assign out_sel     = buf_out[BUF_W-1:WIDTH];
  assign illegal_sel = illegal_q;

endmodule

// File: tb/tb_alu_srcb_stage.sv
// Self-checking bench for alu_srcb_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_srcb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  sel = 3'd0;
  logic [31:0] reg_b = 32'd0;
  logic [15:0] imm = 16'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_sel;
  logic        illegal_sel;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  ent_t last_ent = '0;
  bit   m_illegal = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_srcb_stage #(
    .WIDTH(32), .IMM_W(16), .CONST_VAL(4), .SHAMT(2)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .reg_b(reg_b), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .illegal_sel(illegal_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Operand rules written as plain integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] s, input logic [31:0] rb,
                                         input logic [15:0] im);
    longint v;
    v = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
    case (s)
      3'd0:    return rb;
      3'd1:    return 32'd4;
      3'd2:    return 32'(v);
      3'd3:    return 32'(v * 4);
      3'd4:    return 32'(longint'(im));
      3'd5:    return 32'(longint'(im) * 65536);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    bit   acc;
    bit   pop;
    ent_t e;
    acc    = reset && !flush && in_valid && (q.size() < 2);
    pop    = reset && !flush && out_ready && (q.size() > 0);
    e.sel  = sel;
    e.data = ref_op(sel, reg_b, imm);
    @(posedge clk);
    #1;
    if (!reset) begin
      q.delete();
      last_ent  = '0;
      m_illegal = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        $display("pop  sel=%0d data=%h", q[0].sel, q[0].data);
        void'(q.pop_front());
      end
      if (acc) begin
        $display("push sel=%0d data=%h", e.sel, e.data);
        q.push_back(e);
        if (e.sel >= 3'd6) m_illegal = 1'b1;
      end
    end
    if (q.size() > 0) last_ent = q[0];
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("out_data", out_data, last_ent.data);
    check("out_sel", 32'(out_sel), 32'(last_ent.sel));
    check("illegal_sel", 32'(illegal_sel), 32'(m_illegal));
  endtask

  initial begin
    // Reset
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Sign extend and sign extend + shift, streaming
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 3'd2; imm = 16'hFFFC;
    step();
    check("sext", out_data, 32'hFFFFFFFC);
    sel = 3'd3;
    step();
    check("sext_shl", out_data, 32'hFFFFFFF0);
    in_valid = 1'b0;
    step();

    // Constant then LUI in order
    in_valid = 1'b1; sel = 3'd1;
    step();
    check("const", out_data, 32'h00000004);
    sel = 3'd5; imm = 16'h1234;
    step();
    check("lui", out_data, 32'h12340000);
    in_valid = 1'b0;
    step();

    // Stall, fill, ignore third request, then drain
    out_ready = 1'b0; in_valid = 1'b1;
    sel = 3'd0; reg_b = 32'hA;
    step();
    sel = 3'd4; imm = 16'h8001;
    step();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_data, 32'h0000000A);
    sel = 3'd2; imm = 16'h0007;
    step();
    check("full_hold", out_data, 32'h0000000A);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("zext", out_data, 32'h00008001);
    step();
    check("drained", 32'(out_valid), 32'd0);

    // Flush while full with a request presented
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd1;
    step();
    step();
    flush = 1'b1; sel = 3'd4; imm = 16'h00FF;
    step();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_dropped", 32'(out_valid), 32'd0);

    // Reserved sel sets the sticky flag
    in_valid = 1'b1; sel = 3'd6;
    step();
    check("rsvd_data", out_data, 32'd0);
    check("rsvd_flag", 32'(illegal_sel), 32'd1);
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flag_after_flush", 32'(illegal_sel), 32'd1);
    reset = 1'b0;
    step();
    check("flag_after_reset", 32'(illegal_sel), 32'd0);
    reset = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 63) != 0);
      sel       = flush ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
      reg_b     = $urandom;
      imm       = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
